// File: rtl/mips_pkg.sv
// mips_pkg
//  Shared types and constants for the fetch front end and the decoders it feeds.
//  - fetch_state_t : fetch FSM states
//  - INSTR_BYTES   : PC increment per instruction
//  - RESET_PC_DEFAULT : default PC after reset
//  - OP_*          : main-decoder opcodes (instr[31:26])
//  - word_align()  : clears the byte-offset bits of an address
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_next.sv
// pc_next
//  Combinational next-fetch-PC select for ifetch_unit.
//  Optional feature: define IFETCH_ALIGN_CHK_EN to flag misaligned redirect targets.
//  Ports:
//   fetch_pc        in   32  current fetch address
//   redirect_valid  in   1   redirect this cycle
//   redirect_target in   32  redirect address (low bits ignored)
//   squash          in   1   a redirect is pending behind an in-flight fetch
//   squash_target   in   32  stored (already aligned) pending target
//   target_pc       out  32  aligned target: live redirect wins over stored one
//   next_pc         out  32  target_pc if any redirect is live/pending, else fetch_pc+4
//   align_err       out  1   live redirect target was misaligned (0 unless feature enabled)
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] fetch_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        squash,
  input  logic [31:0] squash_target,
  output logic [31:0] target_pc,
  output logic [31:0] next_pc,
  output logic        align_err
);

  logic [31:0] raw_target;

  // A redirect arriving in the same cycle as a pending one supersedes it.
  assign raw_target = redirect_valid ? redirect_target : squash_target;
  assign target_pc  = word_align(raw_target);
  // The 32-bit add wraps naturally: FFFF_FFFC + 4 = 0.
  assign next_pc    = (redirect_valid || squash) ? target_pc : (fetch_pc + INSTR_BYTES);

`ifdef IFETCH_ALIGN_CHK_EN
  assign align_err = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit
//  Instruction-fetch stage: owns the fetch PC, fetches words over imem req/ack,
//  presents {instr, pc, pcplus4} to decode under valid/ready, and squashes
//  wrong-path fetches on redirects. Fetch timeouts raise a sticky fetch_err.
//  Optional feature: define IFETCH_ALIGN_CHK_EN to also set fetch_err on a
//  misaligned redirect target (target is always word-aligned before use).
//  Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   imem_req/imem_addr         fetch request, address stable while req high
//   imem_ack/imem_rdata        fetch completion and instruction word
//   instr_valid/instr_ready    decode handshake
//   instr/pc/pcplus4           presented instruction, its address, address+4
//   redirect_valid/_target     taken branch / jump from datapath
//   fetch_err                  sticky error flag
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(ACK_TIMEOUT);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic          squash;
  logic [31:0]   squash_target;
  logic [CW-1:0] cnt;

  logic [31:0]   target_pc;
  logic [31:0]   next_pc;
  logic          align_err;

  // fetch_pc only moves on ack (or outside S_REQ), so the address is stable
  // for the whole life of a request.
  assign imem_addr = fetch_pc;

  pc_next u_pc_next (
    .fetch_pc        (fetch_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .squash          (squash),
    .squash_target   (squash_target),
    .target_pc       (target_pc),
    .next_pc         (next_pc),
    .align_err       (align_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      squash        <= 1'b0;
      squash_target <= 32'h0;
      cnt           <= '0;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      instr         <= 32'h0;
      pc            <= 32'h0;
      pcplus4       <= 32'h0;
      fetch_err     <= 1'b0;
    end else begin
      if (align_err) begin
        fetch_err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= target_pc;
          end
          imem_req <= 1'b1;
          state    <= S_REQ;
        end

        S_REQ: begin
          if (imem_ack) begin
            cnt <= '0;
            if (squash || redirect_valid) begin
              // Wrong-path data: drop it and refetch from the target.
              // imem_req stays high; the new address appears next cycle.
              fetch_pc <= next_pc;
              squash   <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              pc          <= fetch_pc;
              pcplus4     <= next_pc;
              fetch_pc    <= next_pc;
              imem_req    <= 1'b0;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end else begin
            if (cnt == CNT_LAST) begin
              fetch_err <= 1'b1;
            end
            if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
            // Cannot retarget the in-flight request; remember where to go.
            if (redirect_valid) begin
              squash        <= 1'b1;
              squash_target <= target_pc;
            end
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            // Held instruction is wrong-path even if decode takes it now.
            fetch_pc    <= target_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end
        end

        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit
//  Randomized bench for ifetch_unit against a handshake-level reference model:
//  the model tracks the architectural PC stream (next PC to deliver, redirect
//  overrides, +4 on consume), whether a request/instruction should be
//  outstanding, the in-flight address after a squash, and the timeout budget.
module tb_ifetch_unit;

  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        fetch_err;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .pc              (pc),
    .pcplus4         (pcplus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_err       (fetch_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference model state.
  logic [31:0] m_pc;          // PC of the next instruction decode should see
  logic [31:0] m_taint_addr;  // address of an in-flight, already-squashed fetch
  bit          m_req, m_valid, m_taint, m_err;
  int          m_cnt;

  // Stimulus knobs.
  int ack_pct, redir_pct, ready_pct;
  bit stall;

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(4))
      0:       t = 32'h0000_0040;
      1:       t = 32'h0000_0100;
      2:       t = 32'hFFFF_FFFC;
      3:       t = 32'h0000_0042;
      default: t = $urandom();
    endcase
    return t;
  endfunction

  task automatic model_reset(input bit rv, input logic [31:0] rt);
    m_req   = 1'b1;
    m_valid = 1'b0;
    m_taint = 1'b0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_pc    = rv ? (rt & ~32'h3) : 32'h0;
`ifdef IFETCH_ALIGN_CHK_EN
    if (rv && rt[1:0] != 2'b00) m_err = 1'b1;
`endif
  endtask

  task automatic do_reset(input bit rv_rel, input logic [31:0] rt_rel);
    @(negedge clk);
    #2;
    reset    = 1'b1;
    imem_ack = 1'b1;  // a late ack around reset must be ignored
    #1;
    check_val("rst_req",     {31'b0, imem_req},    32'h0);
    check_val("rst_valid",   {31'b0, instr_valid}, 32'h0);
    check_val("rst_err",     {31'b0, fetch_err},   32'h0);
    check_val("rst_addr",    imem_addr,            32'h0);
    check_val("rst_instr",   instr,                32'h0);
    check_val("rst_pc",      pc,                   32'h0);
    check_val("rst_pcplus4", pcplus4,              32'h0);
    @(negedge clk);
    @(negedge clk);
    reset           = 1'b0;
    imem_ack        = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = rv_rel;
    redirect_target = rt_rel;
    model_reset(rv_rel, rt_rel);
  endtask

  task automatic step();
    bit          ack, rv, rdy;
    logic [31:0] rt, tgt;
    @(negedge clk);
    // Compare DUT outputs against the model.
    check_val("req",   {31'b0, imem_req},    {31'b0, m_req});
    check_val("valid", {31'b0, instr_valid}, {31'b0, m_valid});
    check_val("err",   {31'b0, fetch_err},   {31'b0, m_err});
    if (m_req) check_val("addr", imem_addr, m_taint ? m_taint_addr : m_pc);
    if (m_valid) begin
      check_val("pc",      pc,      m_pc);
      check_val("instr",   instr,   mem_word(m_pc));
      check_val("pcplus4", pcplus4, m_pc + 32'd4);
    end

    // Drive this cycle's inputs.
    ack = !stall && ($urandom_range(99) < ack_pct);
    rv  = ($urandom_range(99) < redir_pct);
    rdy = ($urandom_range(99) < ready_pct);
    rt  = pick_target();
    imem_ack        = ack;
    imem_rdata      = ack ? mem_word(imem_addr) : $urandom();
    redirect_valid  = rv;
    redirect_target = rt;
    instr_ready     = rdy;

    // Advance the model to the state after the coming edge.
    tgt = rt & ~32'h3;
`ifdef IFETCH_ALIGN_CHK_EN
    if (rv && rt[1:0] != 2'b00) m_err = 1'b1;
`endif
    if (m_req) begin
      if (ack) begin
        m_cnt = 0;
        if (m_taint || rv) begin
          if (rv) m_pc = tgt;
          m_taint = 1'b0;
        end else begin
          m_req   = 1'b0;
          m_valid = 1'b1;
        end
      end else begin
        m_cnt++;
        if (m_cnt >= ACK_TIMEOUT) m_err = 1'b1;
        if (rv) begin
          if (!m_taint) begin
            m_taint_addr = m_pc;
            m_taint      = 1'b1;
          end
          m_pc = tgt;
        end
      end
    end else if (m_valid) begin
      if (rv) begin
        $display("txn drop    pc=%h redirect->%h", m_pc, tgt);
        m_valid = 1'b0;
        m_req   = 1'b1;
        m_pc    = tgt;
      end else if (rdy) begin
        $display("txn consume pc=%h instr=%h", m_pc, mem_word(m_pc));
        m_valid = 1'b0;
        m_req   = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    stall     = 1'b0;
    ack_pct   = 100;
    redir_pct = 0;
    ready_pct = 100;
    do_reset(1'b0, 32'h0);

    // Back-to-back fetches with an ack one cycle after each request.
    repeat (30) step();

    // Decode stalls: hold ready low, instruction must stay put with no request.
    ready_pct = 0;
    repeat (6) step();
    ready_pct = 100;
    repeat (6) step();

    // Mixed random traffic: variable ack latency, back-pressure, redirects.
    ack_pct   = 40;
    redir_pct = 12;
    ready_pct = 60;
    repeat (400) step();

    // Long memory stall with no redirects: must raise and keep fetch_err.
    redir_pct = 0;
    ready_pct = 100;
    stall     = 1'b1;
    repeat (24) step();
    stall     = 1'b0;
    ack_pct   = 50;
    repeat (20) step();

    // Reset in the middle of traffic, released with a redirect in S_IDLE.
    do_reset(1'b1, 32'h0000_0200);
    ack_pct   = 50;
    redir_pct = 10;
    ready_pct = 70;
    repeat (400) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
